// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ahb_arb_pkg : AHB transfer/burst encodings and arbiter modes     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package ahb_arb_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic [2:0] c_hburst_single = 3'b000;
    localparam logic [2:0] c_hburst_incr   = 3'b001;
    localparam logic [2:0] c_hburst_wrap4  = 3'b010;
    localparam logic [2:0] c_hburst_incr4  = 3'b011;
    localparam logic [2:0] c_hburst_wrap8  = 3'b100;
    localparam logic [2:0] c_hburst_incr8  = 3'b101;
    localparam logic [2:0] c_hburst_wrap16 = 3'b110;
    localparam logic [2:0] c_hburst_incr16 = 3'b111;

    localparam int c_arb_fixed = 0;
    localparam int c_arb_rr    = 1;

    // Zero means the burst has no fixed length (SINGLE or INCR).
    function automatic logic [4:0] fixed_burst_len(input logic [2:0] hburst);
        fixed_burst_len = 5'd0;
        case (hburst)
            c_hburst_wrap4,  c_hburst_incr4:  fixed_burst_len = 5'd4;
            c_hburst_wrap8,  c_hburst_incr8:  fixed_burst_len = 5'd8;
            c_hburst_wrap16, c_hburst_incr16: fixed_burst_len = 5'd16;
            c_hburst_single, c_hburst_incr:   fixed_burst_len = 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ahb_rr_picker : first candidate searching upward from ptr+1      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module ahb_rr_picker #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         candidates,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         grant_valid
);

    localparam int c_idx_w = $clog2(NUM_PORTS);

    logic [c_idx_w-1:0] w_idx;

    // Walk from the farthest offset down to ptr+1 so the nearest candidate wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = c_idx_w'((int'(ptr) + k) % NUM_PORTS);
            if (candidates[w_idx]) begin
                grant_idx   = w_idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ahb_arbiter_rr : AHB slave-port arbiter, fixed or round-robin    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module ahb_arbiter_rr
    import ahb_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int ARB_MODE  = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 arb_hold
);

    logic [3:0]           r_beat_cnt;
    logic [PORT_W-1:0]    r_rr_ptr;

    logic [4:0]           w_burst_len;
    logic                 w_fixed_burst;
    logic                 w_burst_hold;
    logic                 w_hold;
    logic                 w_owner_active;
    logic [NUM_PORTS-1:0] w_candidates;
    logic [PORT_W-1:0]    w_pick_ptr;
    logic [PORT_W-1:0]    w_grant_idx;
    logic                 w_grant_valid;
    logic [PORT_W-1:0]    w_owner_next;
    logic                 w_no_port_next;
    logic                 w_ptr_load;
    logic [3:0]           w_beat_next;

    assign w_burst_len   = fixed_burst_len(HBURSTM);
    assign w_fixed_burst = (w_burst_len != 5'd0);

    // IDLE or a non-fixed NONSEQ never holds, so an early-terminated burst releases at once.
    assign w_burst_hold = ((HTRANSM == c_htrans_nonseq) && w_fixed_burst)
                       || ((HTRANSM == c_htrans_seq)  && (r_beat_cnt > 4'd1))
                       || ((HTRANSM == c_htrans_busy) && (r_beat_cnt != 4'd0))
                       || ((HBURSTM == c_hburst_incr)
                           && ((HTRANSM == c_htrans_seq) || (HTRANSM == c_htrans_busy)));

    assign w_hold   = HMASTLOCKM | w_burst_hold;
    assign arb_hold = w_hold;

    assign w_owner_active = HSELM && (HTRANSM != c_htrans_idle);

    always_comb begin
        w_candidates = req_port;
        if (w_owner_active) begin
            w_candidates[addr_in_port] = 1'b1;
        end
    end

    // Fixed priority is the rotating search anchored just below port 0.
    assign w_pick_ptr = (ARB_MODE == c_arb_rr) ? r_rr_ptr : PORT_W'(NUM_PORTS - 1);

    ahb_rr_picker #(
        .NUM_PORTS  (NUM_PORTS)
    ) u_picker (
        .candidates (w_candidates),
        .ptr        (w_pick_ptr),
        .grant_idx  (w_grant_idx),
        .grant_valid(w_grant_valid)
    );

    always_comb begin
        w_owner_next   = addr_in_port;
        w_no_port_next = 1'b0;
        w_ptr_load     = 1'b0;
        if (!w_hold) begin
            if (w_grant_valid) begin
                w_owner_next = w_grant_idx;
                w_ptr_load   = 1'b1;
            end else if (!HSELM) begin
                w_no_port_next = 1'b1;
            end
        end
    end

    always_comb begin
        w_beat_next = r_beat_cnt;
        case (HTRANSM)
            c_htrans_nonseq: w_beat_next = w_fixed_burst ? 4'(w_burst_len - 5'd1) : 4'd0;
            c_htrans_seq:    if (r_beat_cnt != 4'd0) w_beat_next = r_beat_cnt - 4'd1;
            c_htrans_idle:   w_beat_next = 4'd0;
            default:         w_beat_next = r_beat_cnt;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            r_beat_cnt   <= 4'd0;
            r_rr_ptr     <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            addr_in_port <= w_owner_next;
            no_port      <= w_no_port_next;
            r_beat_cnt   <= w_beat_next;
            if (w_ptr_load) begin
                r_rr_ptr <= w_grant_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_ahb_arbiter_rr : fixed and round-robin arbiters vs. a model   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_ahb_arbiter_rr;

    localparam int N = 4;

    logic         HCLK = 1'b0;
    logic         HRESET = 1'b1;
    logic [N-1:0] req_port = '0;
    logic         HREADYM = 1'b1;
    logic         HSELM = 1'b0;
    logic [1:0]   HTRANSM = 2'b00;
    logic [2:0]   HBURSTM = 3'b000;
    logic         HMASTLOCKM = 1'b0;

    logic [1:0]   addr_fix, addr_rr;
    logic         nop_fix, nop_rr, hold_fix, hold_rr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per DUT: index 0 = fixed priority, 1 = round-robin.
    int m_owner [2];
    int m_nop   [2];
    int m_beats [2];
    int m_last  [2];

    always #5 HCLK = ~HCLK;

    ahb_arbiter_rr #(.NUM_PORTS(N), .ARB_MODE(0)) dut_fix (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_fix), .no_port(nop_fix), .arb_hold(hold_fix)
    );

    ahb_arbiter_rr #(.NUM_PORTS(N), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_rr), .no_port(nop_rr), .arb_hold(hold_rr)
    );

    function automatic int obs_addr(int m);
        return (m == 0) ? int'(addr_fix) : int'(addr_rr);
    endfunction

    function automatic int obs_nop(int m);
        return (m == 0) ? int'(nop_fix) : int'(nop_rr);
    endfunction

    function automatic int obs_hold(int m);
        return (m == 0) ? int'(hold_fix) : int'(hold_rr);
    endfunction

    function automatic int fixed_len(logic [2:0] b);
        if (b[2:1] != 2'b00) return 2 << b[2:1];
        return 0;
    endfunction

    function automatic int model_hold(int m);
        bit incr;
        incr = (HBURSTM == 3'b001);
        case (HTRANSM)
            2'b10:   return int'(HMASTLOCKM || (fixed_len(HBURSTM) != 0));
            2'b11:   return int'(HMASTLOCKM || (m_beats[m] > 1) || incr);
            2'b01:   return int'(HMASTLOCKM || (m_beats[m] != 0) || incr);
            default: return int'(HMASTLOCKM);
        endcase
    endfunction

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (HRESET) begin
                m_owner[m] = 0;
                m_nop[m]   = 1;
                m_beats[m] = 0;
                m_last[m]  = N - 1;
            end else if (HREADYM) begin
                int h;
                int win;
                int p;
                h   = model_hold(m);
                win = -1;
                if (h != 0) begin
                    m_nop[m] = 0;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        p = (m == 0) ? k : (m_last[m] + 1 + k) % N;
                        if (win < 0 && (req_port[p[1:0]] ||
                            (p == m_owner[m] && HSELM && HTRANSM != 2'b00))) win = p;
                    end
                    if (win >= 0) begin
                        m_owner[m] = win;
                        m_nop[m]   = 0;
                        m_last[m]  = win;
                    end else begin
                        m_nop[m] = HSELM ? 0 : 1;
                    end
                end
                case (HTRANSM)
                    2'b10:   m_beats[m] = (fixed_len(HBURSTM) != 0) ? fixed_len(HBURSTM) - 1 : 0;
                    2'b11:   if (m_beats[m] > 0) m_beats[m] = m_beats[m] - 1;
                    2'b00:   m_beats[m] = 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        HRESET = 1'b0; HREADYM = 1'b1; HSELM = 1'b0; HTRANSM = 2'b00;
        HBURSTM = 3'b000; HMASTLOCKM = 1'b0; req_port = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req_port = 4'b0100;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs_addr(m) !== 2) begin
                n_bad++; $display("FAIL pre_reset_grant dut%0d got %0d exp 2", m, obs_addr(m));
            end
        end
        HRESET = 1'b1; HREADYM = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs_addr(m) !== 0 || obs_nop(m) !== 1) begin
                n_bad++; $display("FAIL reset_state dut%0d got addr=%0d nop=%0d exp addr=0 nop=1",
                                  m, obs_addr(m), obs_nop(m));
            end
        end
        idle_inputs();
        repeat (4) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs_addr(m) !== 0 || obs_nop(m) !== 1) begin
                    n_bad++; $display("FAIL idle_no_port dut%0d got addr=%0d nop=%0d exp addr=0 nop=1",
                                      m, obs_addr(m), obs_nop(m));
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req_port = 4'b1010;
        tick();
        n_cmp++;
        if (addr_fix !== 2'd1 || nop_fix !== 1'b0) begin
            n_bad++; $display("FAIL fixed_1010 got addr=%0d nop=%0d exp addr=1 nop=0", addr_fix, nop_fix);
        end
        req_port = 4'b1001;
        tick();
        n_cmp++;
        if (addr_fix !== 2'd0) begin
            n_bad++; $display("FAIL fixed_1001 got %0d exp 0", addr_fix);
        end
        n_cmp++;
        if (addr_rr !== 2'd3) begin
            n_bad++; $display("FAIL rr_after_1 got %0d exp 3", addr_rr);
        end
    endtask

    task automatic test_round_robin();
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_port = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (addr_rr !== 2'(exp_rr[i]) || addr_fix !== 2'd0) begin
                n_bad++; $display("FAIL rr_sequence step%0d got rr=%0d fix=%0d exp rr=%0d fix=0",
                                  i, addr_rr, addr_fix, exp_rr[i]);
            end
        end
    endtask

    task automatic test_burst_incr8();
        int exp_owner;
        do_reset();
        req_port = 4'b0100;
        tick();
        req_port = 4'b0001; HSELM = 1'b1; HBURSTM = 3'b101;
        for (int b = 0; b < 8; b++) begin
            HTRANSM = (b == 0) ? 2'b10 : 2'b11;
            if (b == 3) begin
                HREADYM = 1'b0;
                #1;
                tick();
                for (int m = 0; m < 2; m++) begin
                    n_cmp++;
                    if (obs_addr(m) !== 2) begin
                        n_bad++; $display("FAIL burst_stall dut%0d got %0d exp 2", m, obs_addr(m));
                    end
                end
                HREADYM = 1'b1;
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs_hold(m) !== int'(b < 7)) begin
                    n_bad++; $display("FAIL burst_hold beat%0d dut%0d got %0d exp %0d",
                                      b, m, obs_hold(m), int'(b < 7));
                end
            end
            tick();
            exp_owner = (b < 7) ? 2 : 0;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs_addr(m) !== exp_owner) begin
                    n_bad++; $display("FAIL burst_owner beat%0d dut%0d got %0d exp %0d",
                                      b, m, obs_addr(m), exp_owner);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        req_port = 4'b0100;
        tick();
        req_port = 4'b0001; HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b000; HMASTLOCKM = 1'b1;
        repeat (5) begin
            #1;
            n_cmp++;
            if (hold_fix !== 1'b1 || hold_rr !== 1'b1) begin
                n_bad++; $display("FAIL lock_hold got fix=%0d rr=%0d exp 1", hold_fix, hold_rr);
            end
            tick();
            n_cmp++;
            if (addr_fix !== 2'd2 || addr_rr !== 2'd2) begin
                n_bad++; $display("FAIL lock_owner got fix=%0d rr=%0d exp 2", addr_fix, addr_rr);
            end
        end
        HMASTLOCKM = 1'b0; HTRANSM = 2'b00; HREADYM = 1'b0;
        tick();
        n_cmp++;
        if (addr_fix !== 2'd2 || addr_rr !== 2'd2) begin
            n_bad++; $display("FAIL unlock_stall got fix=%0d rr=%0d exp 2", addr_fix, addr_rr);
        end
        HREADYM = 1'b1;
        tick();
        n_cmp++;
        if (addr_fix !== 2'd0 || addr_rr !== 2'd0 || nop_fix !== 1'b0 || nop_rr !== 1'b0) begin
            n_bad++; $display("FAIL unlock_grant got fix=%0d rr=%0d exp 0", addr_fix, addr_rr);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_port = 4'b0100;
        tick();
        req_port = '0; HSELM = 1'b1; HBURSTM = 3'b011; HTRANSM = 2'b10;
        tick();
        HTRANSM = 2'b11;
        tick();
        #1;
        n_cmp++;
        if (hold_fix !== 1'b1 || hold_rr !== 1'b1) begin
            n_bad++; $display("FAIL incr4_hold got fix=%0d rr=%0d exp 1", hold_fix, hold_rr);
        end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        n_cmp++;
        if (nop_fix !== 1'b1 || nop_rr !== 1'b1 || addr_fix !== 2'd0 || addr_rr !== 2'd0) begin
            n_bad++; $display("FAIL midburst_reset got nop=%0d/%0d addr=%0d/%0d exp nop=1 addr=0",
                              nop_fix, nop_rr, addr_fix, addr_rr);
        end
        HTRANSM = 2'b11;
        #1;
        n_cmp++;
        if (hold_fix !== 1'b0 || hold_rr !== 1'b0) begin
            n_bad++; $display("FAIL residual_hold_seq got fix=%0d rr=%0d exp 0", hold_fix, hold_rr);
        end
        HTRANSM = 2'b01;
        #1;
        n_cmp++;
        if (hold_fix !== 1'b0 || hold_rr !== 1'b0) begin
            n_bad++; $display("FAIL residual_hold_busy got fix=%0d rr=%0d exp 0", hold_fix, hold_rr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            HRESET     = ($urandom_range(0, 39) == 0);
            HREADYM    = ($urandom_range(0, 3) != 0);
            HSELM      = 1'($urandom_range(0, 1));
            HTRANSM    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) HBURSTM = 3'($urandom_range(0, 7));
            HMASTLOCKM = ($urandom_range(0, 7) == 0);
            req_port   = 4'($urandom_range(0, 15));
            #1;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs_hold(m) !== model_hold(m)) begin
                    n_bad++; $display("FAIL rand_hold cyc%0d dut%0d got %0d exp %0d",
                                      c, m, obs_hold(m), model_hold(m));
                end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs_addr(m) !== m_owner[m] || obs_nop(m) !== m_nop[m]) begin
                    n_bad++; $display("FAIL rand_out cyc%0d dut%0d got addr=%0d nop=%0d exp addr=%0d nop=%0d",
                                      c, m, obs_addr(m), obs_nop(m), m_owner[m], m_nop[m]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_burst_incr8();
        test_lock();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
